// File: rtl/seq_divider_16bit_pkg.sv
// Shared definitions for the sequential divider: default operand width and FSM state encoding.
package seq_divider_16bit_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FIX  = 2'd3
  } div_state_e;

endpackage

// File: rtl/seq_divider_16bit_cla_subtractor.sv
// Combinational N-bit subtractor a + ~b + 1 built on a parallel-prefix carry lookahead.
// borrow_o is high when a < b (unsigned).
module cla_subtractor #(
  parameter int unsigned N = 17
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N-1:0] g, p, gs, ps, gn, pn;
  logic [N:0]   c;

  always_comb begin
    g  = a_i & ~b_i;
    p  = a_i ^ ~b_i;
    gn = '0;
    pn = '0;
    // Carry-in of 1 is folded into bit 0 so gs[i] ends up as the carry out of bit i.
    gs    = g;
    gs[0] = g[0] | p[0];
    ps    = p;
    for (int unsigned d = 1; d < N; d = d * 2) begin
      gn = gs;
      pn = ps;
      for (int unsigned i = d; i < N; i++) begin
        gn[i] = gs[i] | (ps[i] & gs[i-d]);
        pn[i] = ps[i] & ps[i-d];
      end
      gs = gn;
      ps = pn;
    end
    c        = {gs, 1'b1};
    diff_o   = p ^ c[N-1:0];
    borrow_o = ~c[N];
  end

endmodule

// File: rtl/seq_divider_16bit.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIVIDER_SIGNED_EN for two's-complement operands (adds one sign fix-up edge).
module seq_divider_16bit
  import seq_divider_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic             accept, last_iter, t_neg;
  logic [WIDTH:0]   sub_a, sub_b, t_diff;
  logic [WIDTH-1:0] q_shift, r_next, dividend_mag, divisor_mag;
  logic             t_diff_msb_unused;

`ifdef DIVIDER_SIGNED_EN
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
`endif

  assign sub_a = {r_q, q_q[WIDTH-1]};
  assign sub_b = {1'b0, dvs_q};

  cla_subtractor #(.N(WIDTH + 1)) u_sub (
    .a_i      (sub_a),
    .b_i      (sub_b),
    .diff_o   (t_diff),
    .borrow_o (t_neg)
  );

  // The restored remainder is always below the divisor, so the difference MSB equals the borrow.
  assign t_diff_msb_unused = t_diff[WIDTH];

  assign q_shift   = {q_q[WIDTH-2:0], ~t_neg};
  assign r_next    = t_neg ? sub_a[WIDTH-1:0] : t_diff[WIDTH-1:0];
  assign last_iter = (cnt_q == '0);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (divisor == '0) ? DONE : RUN;
`ifdef DIVIDER_SIGNED_EN
      RUN:  if (last_iter) state_d = FIX;
`else
      RUN:  if (last_iter) state_d = DONE;
`endif
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    r_d   = r_q;
    q_d   = q_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    qneg_d = qneg_q;
    rneg_d = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (divisor == '0) begin
            quo_d = '1;
            rem_d = dividend;
            dbz_d = 1'b1;
          end else begin
            r_d   = '0;
            q_d   = dividend_mag;
            dvs_d = divisor_mag;
            cnt_d = CW'(WIDTH - 1);
`ifdef DIVIDER_SIGNED_EN
            qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d = dividend[WIDTH-1];
`endif
          end
        end
      end
      RUN: begin
        r_d   = r_next;
        q_d   = q_shift;
        cnt_d = cnt_q - CW'(1);
`ifndef DIVIDER_SIGNED_EN
        if (last_iter) begin
          quo_d = q_shift;
          rem_d = r_next;
          dbz_d = 1'b0;
        end
`endif
      end
      FIX: begin
`ifdef DIVIDER_SIGNED_EN
        quo_d = qneg_q ? -q_q : q_q;
        rem_d = rneg_q ? -r_q : r_q;
        dbz_d = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      q_q   <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      r_q   <= r_d;
      q_q   <= q_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
`endif
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Directed self-checking bench for seq_divider_16bit; latencies count edges from the accepting edge inclusive.
module tb_seq_divider_16bit;

  localparam int unsigned W = 16;
`ifdef DIVIDER_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, div_by_zero, busy;
  logic [W-1:0] dividend, divisor, quotient, remainder;

  int checks = 0;
  int errors = 0;

  seq_divider_16bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then wait (bounded) for out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int edges,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 16'h0000;
    edges = 1;
    while (out_valid !== 1'b1 && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("handshake_idle", {out_valid, in_ready, busy}, 3'b010);
  endtask

  int           edges;
  logic [W-1:0] q, r, a, b, eq, er;
  logic         z;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_results", {quotient, remainder, div_by_zero}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd1234, 16'd0, edges, q, r, z);
    chk("dbz_latency", edges, 1);
    chk("dbz_flag", z, 1'b1);
    chk("dbz_quotient", q, 16'hFFFF);
    chk("dbz_remainder", r, 16'd1234);
    finish_op();

`ifdef DIVIDER_SIGNED_EN
    run_op(16'hFFF9, 16'd2, edges, q, r, z);
    chk("s_m7d2_latency", edges, LAT);
    chk("s_m7d2_q", q, 16'hFFFD);
    chk("s_m7d2_r", r, 16'hFFFF);
    chk("s_m7d2_dbz", z, 1'b0);
    finish_op();
    run_op(16'h8000, 16'hFFFF, edges, q, r, z);
    chk("s_min_by_m1", {q, r}, {16'h8000, 16'h0000});
    finish_op();
    run_op(16'd7, 16'hFFFE, edges, q, r, z);
    chk("s_7_by_m2", {q, r}, {16'hFFFD, 16'h0001});
    finish_op();
`else
    run_op(16'd100, 16'd7, edges, q, r, z);
    chk("t1_latency", edges, LAT);
    chk("t1_quotient", q, 16'd14);
    chk("t1_remainder", r, 16'd2);
    chk("t1_dbz", z, 1'b0);
    finish_op();

    run_op(16'hFFFF, 16'h0001, edges, q, r, z);
    chk("t2_ffff_by_1", {q, r}, {16'hFFFF, 16'h0000});
    finish_op();
    run_op(16'd5, 16'd9, edges, q, r, z);
    chk("t2_5_by_9", {q, r}, {16'd0, 16'd5});
    finish_op();

    run_op(16'd100, 16'd7, edges, q, r, z);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {out_valid, in_ready, quotient, remainder}, {1'b1, 1'b0, 16'd14, 16'd2});
    end
    finish_op();

    @(negedge clk);
    dividend = 16'd500; divisor = 16'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    chk("mid_run_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {in_ready, out_valid, busy}, 3'b100);
    chk("mid_rst_results", {quotient, remainder, div_by_zero}, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd9, 16'd3, edges, q, r, z);
    chk("post_rst_9_by_3", {8'(edges), q, r}, {8'(LAT), 16'd3, 16'd0});
    finish_op();

    for (int i = 0; i < 1500; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      run_op(a, b, edges, q, r, z);
      if (b == '0) begin
        eq = '1;
        er = a;
        chk($sformatf("rand %0d/0", a), {8'(edges), z, q, r}, {8'd1, 1'b1, eq, er});
      end else begin
        eq = a / b;
        er = a % b;
        chk($sformatf("rand %0d/%0d", a, b), {8'(edges), z, q, r}, {8'(LAT), 1'b0, eq, er});
        chk("rand_identity", {(32'(q) * 32'(b) + 32'(r)) == 32'(a), r < b}, 2'b11);
      end
      finish_op();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
